// File: rtl/avalon_arg_top.sv
// Accelerator shell: Avalon-MM slave register file in front of a square-by-accumulation engine,
// plus a 2-entry sticky debug flag array on its own io_ port set.
// Ports: clock/reset (async, active-low); io_S_AVALON_* word-addressed slave with 1-cycle registered
// readdata; io_raddr/io_waddr/io_wen/io_rdata debug flags (set-only, combinational read).
// Latency: readdata follows address by one cycle; a run of N takes max(N,1) cycles in RUN.
// Backpressure: none; the slave never stalls, and writes to read-only or unmapped words are dropped.
module avalon_arg_top #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int NUM_ARGIN  = 2,
  parameter int NUM_ARGOUT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] io_S_AVALON_address,
  input  logic              io_S_AVALON_chipselect,
  input  logic              io_S_AVALON_write,
  input  logic              io_S_AVALON_read,
  input  logic [DATA_W-1:0] io_S_AVALON_writedata,
  output logic [DATA_W-1:0] io_S_AVALON_readdata,
  input  logic              io_raddr,
  input  logic              io_waddr,
  input  logic              io_wen,
  output logic              io_rdata
);

  // Word map: 0 COMMAND, 1 STATUS, then ARGIN block, then ARGOUT block.
  localparam int ADDR_CMD       = 0;
  localparam int ADDR_STATUS    = 1;
  localparam int ADDR_ARGIN_LO  = 2;
  localparam int ADDR_ARGOUT_LO = ADDR_ARGIN_LO + NUM_ARGIN;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] cmd_q;
  logic [DATA_W-1:0] argin_q  [NUM_ARGIN];
  logic [DATA_W-1:0] argout_q [NUM_ARGOUT];
  logic [DATA_W-1:0] n_q, acc_q, cnt_q;
  logic [DATA_W-1:0] acc_nxt, cnt_nxt;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] status;
  logic [1:0]        flag_q;
  logic              start, step, finish;

  // The bus qualifiers are part of the interface but do not gate transfers.
  logic unused_inputs;
  assign unused_inputs = io_S_AVALON_chipselect ^ io_S_AVALON_read;

  assign acc_nxt = acc_q + n_q;
  assign cnt_nxt = cnt_q + 1'b1;
  assign status  = {{(DATA_W-2){1'b0}}, state_q == ST_RUN, state_q == ST_DONE};

  // Next-state logic. Abort (enable dropped) takes priority over completion.
  // N==0 finishes after one RUN cycle; acc stays 0 because it adds N==0.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_q[0]) begin
          state_d = ST_RUN;
          start   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!cmd_q[0]) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (cnt_nxt == n_q || n_q == '0) begin
            state_d = ST_DONE;
            finish  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!cmd_q[0]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_ARGOUT; i++) argout_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        // N is captured here so later ARGIN0 writes cannot disturb this run.
        n_q   <= argin_q[0];
        acc_q <= '0;
        cnt_q <= '0;
      end
      if (step) begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_nxt;
      end
      if (finish) begin
        argout_q[0] <= acc_nxt;
        argout_q[1] <= cnt_nxt;
      end
    end
  end

  // Host-writable registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_q <= '0;
      for (int i = 0; i < NUM_ARGIN; i++) argin_q[i] <= '0;
    end else if (io_S_AVALON_write) begin
      if (io_S_AVALON_address == ADDR_W'(ADDR_CMD)) cmd_q <= io_S_AVALON_writedata;
      for (int i = 0; i < NUM_ARGIN; i++) begin
        if (io_S_AVALON_address == ADDR_W'(ADDR_ARGIN_LO + i)) argin_q[i] <= io_S_AVALON_writedata;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (io_S_AVALON_address == ADDR_W'(ADDR_CMD))    rd_mux = cmd_q;
    if (io_S_AVALON_address == ADDR_W'(ADDR_STATUS)) rd_mux = status;
    for (int i = 0; i < NUM_ARGIN; i++) begin
      if (io_S_AVALON_address == ADDR_W'(ADDR_ARGIN_LO + i)) rd_mux = argin_q[i];
    end
    for (int i = 0; i < NUM_ARGOUT; i++) begin
      if (io_S_AVALON_address == ADDR_W'(ADDR_ARGOUT_LO + i)) rd_mux = argout_q[i];
    end
  end

  // readdata tracks address every cycle regardless of the read strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) io_S_AVALON_readdata <= '0;
    else        io_S_AVALON_readdata <= rd_mux;
  end

  // Debug flags are sticky: only reset clears them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      flag_q <= '0;
    else if (io_wen) flag_q[io_waddr] <= 1'b1;
  end

  assign io_rdata = flag_q[io_raddr];

endmodule

// File: tb/tb_avalon_arg_top.sv
module tb_avalon_arg_top;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [8:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        io_raddr = 1'b0;
  logic        io_waddr = 1'b0;
  logic        io_wen = 1'b0;
  logic        io_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference state: what the register file should hold, derived from the register map rules.
  logic [31:0] exp_cmd;
  logic [31:0] exp_argin [2];
  logic [31:0] exp_out0, exp_out1;

  avalon_arg_top dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_S_AVALON_address   (address),
    .io_S_AVALON_chipselect(chipselect),
    .io_S_AVALON_write     (write),
    .io_S_AVALON_read      (read),
    .io_S_AVALON_writedata (writedata),
    .io_S_AVALON_readdata  (readdata),
    .io_raddr              (io_raddr),
    .io_waddr              (io_waddr),
    .io_wen                (io_wen),
    .io_rdata              (io_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    address   = 9'(a);
    writedata = d;
    write     = 1'b1;
    chipselect = 1'b1;
    @(posedge clock);
    #1;
    write      = 1'b0;
    chipselect = 1'b0;
    // Model of the register file: only RW words keep written data.
    if (a == 0) exp_cmd = d;
    if (a == 2) exp_argin[0] = d;
    if (a == 3) exp_argin[1] = d;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    address = 9'(a);
    read    = 1'b1;
    @(posedge clock);
    #1;
    read = 1'b0;
    d    = readdata;
  endtask

  // Poll STATUS.done with a bounded budget; a timeout is a failed check.
  task automatic wait_done(input string tag);
    logic [31:0] d;
    logic        ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      rd(1, d);
      if (d[0]) ok = 1'b1;
    end
    chk(tag, {31'b0, ok}, 32'd1);
  endtask

  // Expected engine result for a completed run of N.
  function automatic logic [31:0] sq(input logic [31:0] n);
    return n * n;
  endfunction
  function automatic logic [31:0] run_cycles(input logic [31:0] n);
    return (n == 0) ? 32'd1 : n;
  endfunction

  task automatic model_reset();
    exp_cmd = '0; exp_argin[0] = '0; exp_argin[1] = '0; exp_out0 = '0; exp_out1 = '0;
  endtask

  task automatic check_all_regs(input string tag);
    logic [31:0] d;
    rd(0, d); chk({tag, "_cmd"}, d, exp_cmd);
    rd(1, d); chk({tag, "_status"}, d, 32'd0);
    rd(2, d); chk({tag, "_argin0"}, d, exp_argin[0]);
    rd(3, d); chk({tag, "_argin1"}, d, exp_argin[1]);
    rd(4, d); chk({tag, "_argout0"}, d, exp_out0);
    rd(5, d); chk({tag, "_argout1"}, d, exp_out1);
  endtask

  initial begin
    logic [31:0] d, n, c;

    // ---- Reset state ----
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_io_rdata", {31'b0, io_rdata}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    check_all_regs("post_rst");
    rd(6, d);   chk("unmapped6", d, 32'd0);
    rd(300, d); chk("unmapped300", d, 32'd0);

    // ---- ARGIN readback, RO/unmapped write ignored ----
    wr(2, 32'd4);
    address = 9'd2;
    repeat (2) @(posedge clock);
    #1;
    chk("argin0_hold", readdata, 32'd4);
    wr(4, 32'd7);
    rd(4, d); chk("argout0_ro", d, 32'd0);
    wr(1, 32'hFFFF_FFFF);
    rd(1, d); chk("status_ro", d, 32'd0);
    wr(7, 32'h1234);
    rd(7, d); chk("unmapped_wr", d, 32'd0);

    // ---- Basic run N=4 ----
    wr(0, 32'd1);
    repeat (20) @(posedge clock);
    #1;
    exp_out0 = sq(32'd4); exp_out1 = run_cycles(32'd4);
    rd(1, d); chk("run4_status", d, 32'd1);
    rd(4, d); chk("run4_out0", d, exp_out0);
    rd(5, d); chk("run4_out1", d, exp_out1);

    // ---- Re-run with mid-run ARGIN0 write ----
    wr(0, 32'd0);
    rd(1, d); rd(1, d); chk("clr_status", d, 32'd0);
    wr(2, 32'd3);
    wr(0, 32'd1);
    wr(2, 32'd5);  // lands on the IDLE->RUN edge; N=3 is already being captured
    n = 32'd3;
    wait_done("rerun_done");
    exp_out0 = sq(n); exp_out1 = run_cycles(n);
    rd(4, d); chk("rerun_out0", d, exp_out0);
    rd(5, d); chk("rerun_out1", d, exp_out1);
    rd(2, d); chk("rerun_argin0", d, exp_argin[0]);

    // ---- N=0 ----
    wr(0, 32'd0);
    repeat (2) @(posedge clock);
    wr(2, 32'd0);
    wr(0, 32'd1);
    wait_done("zero_done");
    exp_out0 = sq(32'd0); exp_out1 = run_cycles(32'd0);
    rd(4, d); chk("zero_out0", d, exp_out0);
    rd(5, d); chk("zero_out1", d, exp_out1);

    // ---- Abort ----
    wr(0, 32'd0);
    repeat (2) @(posedge clock);
    wr(2, 32'd1000);
    wr(0, 32'd1);
    repeat (2) @(posedge clock);
    #1;
    rd(1, d); chk("abort_busy", d, 32'd2);
    repeat (3) @(posedge clock);
    wr(0, 32'd0);
    repeat (3) @(posedge clock);
    rd(1, d); chk("abort_status", d, 32'd0);
    rd(4, d); chk("abort_out0", d, exp_out0);
    rd(5, d); chk("abort_out1", d, exp_out1);

    // ---- Randomized runs against the model ----
    for (int it = 0; it < 6; it++) begin
      n = 32'($urandom_range(0, 40));
      c = $urandom | 32'd1;
      wr(2, n);
      wr(3, $urandom);
      rd(2, d); chk("rnd_argin0", d, exp_argin[0]);
      rd(3, d); chk("rnd_argin1", d, exp_argin[1]);
      wr(0, c);
      wr(2, $urandom);  // must not disturb the latched N
      rd(0, d); chk("rnd_cmd", d, exp_cmd);
      wait_done("rnd_done");
      exp_out0 = sq(n); exp_out1 = run_cycles(n);
      rd(4, d); chk("rnd_out0", d, exp_out0);
      rd(5, d); chk("rnd_out1", d, exp_out1);
      wr(0, c & ~32'd1);
      rd(1, d); rd(1, d); chk("rnd_clear", d, 32'd0);
    end

    // ---- Debug flags ----
    io_raddr = 1'b1; #1;
    chk("flag1_init", {31'b0, io_rdata}, 32'd0);
    @(negedge clock);
    io_wen = 1'b1; io_waddr = 1'b1;
    @(negedge clock);
    io_wen = 1'b0; io_waddr = 1'b0;
    io_raddr = 1'b1; #1;
    chk("flag1_set", {31'b0, io_rdata}, 32'd1);
    io_raddr = 1'b0; #1;
    chk("flag0_clear", {31'b0, io_rdata}, 32'd0);
    @(negedge clock);
    io_wen = 1'b1; io_waddr = 1'b0;
    @(negedge clock);
    io_wen = 1'b0; #1;
    chk("flag0_set", {31'b0, io_rdata}, 32'd1);

    // ---- Reset mid-run ----
    wr(2, 32'd50);
    wr(0, 32'd1);
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("midrst_readdata", readdata, 32'd0);
    chk("midrst_flag0", {31'b0, io_rdata}, 32'd0);
    io_raddr = 1'b1; #1;
    chk("midrst_flag1", {31'b0, io_rdata}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    check_all_regs("midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
